// File: rtl/segrw_param_if.sv
// Stream bundle for the parametrised segment read/write operator.
// Each stream carries _d data, _e end-of-stream, _v valid and _b back-pressure.
// The master side produces the addr/write/dataW streams and consumes dataR.
interface segrw_param_if #(
    parameter int AW = 4,
    parameter int DW = 8
);
    logic [AW-1:0] addr_d;
    logic          addr_e;
    logic          addr_v;
    logic          addr_b;
    logic          write_d;
    logic          write_e;
    logic          write_v;
    logic          write_b;
    logic [DW-1:0] dataW_d;
    logic          dataW_e;
    logic          dataW_v;
    logic          dataW_b;
    logic [DW-1:0] dataR_d;
    logic          dataR_e;
    logic          dataR_v;
    logic          dataR_b;
    logic          oob;

    modport master (
        output addr_d, addr_e, addr_v, input addr_b,
        output write_d, write_e, write_v, input write_b,
        output dataW_d, dataW_e, dataW_v, input dataW_b,
        input dataR_d, dataR_e, dataR_v, output dataR_b,
        input oob
    );

    modport slave (
        input addr_d, addr_e, addr_v, output addr_b,
        input write_d, write_e, write_v, output write_b,
        input dataW_d, dataW_e, dataW_v, output dataW_b,
        output dataR_d, dataR_e, dataR_v, input dataR_b,
        output oob
    );
endinterface

// File: rtl/segrw_param.sv
// Parametrised segment read/write operator: DEPTH words of DW bits, driven by
// an address stream, an op stream (1 = write) and a write-data stream, with a
// single-entry registered read output and a sticky out-of-range flag.
// Optional macro SEGRW_PARAM_CLEAR_EN: after reset release the memory is
// zeroed one word per cycle (CLEAR state) before normal operation starts.
module segrw_param #(
    parameter int AW    = 4,
    parameter int DW    = 8,
    parameter int DEPTH = 16
) (
    input  logic        clock,
    input  logic        reset,
    segrw_param_if.slave bus
);
    localparam int            IW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0]   DEPTH_V = (AW + 1)'(DEPTH);

    typedef enum logic [1:0] {ST_RUN, ST_DONE, ST_CLEAR} state_t;

    state_t        state_q, state_nx;
    logic [DW-1:0] mem [DEPTH];

    logic [DW-1:0] rd_d_p1;
    logic          rd_e_p1;
    logic          vld_p1;
    logic          oob_q;

    logic          in_range;
    logic          slot_free;
    logic [IW-1:0] ridx;
    logic          rd_fire, wr_fire, wr_eos, eos_fire, take;
    logic          mem_we;
    logic [IW-1:0] mem_wa;
    logic [DW-1:0] mem_wd;

`ifdef SEGRW_PARAM_CLEAR_EN
    logic [IW-1:0] clr_idx;
`endif

    assign in_range  = {1'b0, bus.addr_d} < DEPTH_V;
    assign slot_free = !vld_p1 || !bus.dataR_b;
    assign ridx      = bus.addr_d[IW-1:0];

    // Next-state and firing decisions; nothing fires while reset is asserted
    always_comb begin
        state_nx = state_q;
        rd_fire  = 1'b0;
        wr_fire  = 1'b0;
        wr_eos   = 1'b0;
        eos_fire = 1'b0;
        case (state_q)
            ST_RUN: begin
                if (reset && bus.addr_v && bus.write_v) begin
                    if (bus.addr_e || bus.write_e) begin
                        if (slot_free) begin
                            eos_fire = 1'b1;
                            state_nx = ST_DONE;
                        end
                    end else if (!bus.write_d) begin
                        rd_fire = slot_free;
                    end else if (bus.dataW_v) begin
                        if (!bus.dataW_e) begin
                            wr_fire = 1'b1;
                        end else if (slot_free) begin
                            wr_eos   = 1'b1;
                            state_nx = ST_DONE;
                        end
                    end
                end
            end
            ST_DONE: state_nx = ST_DONE;
`ifdef SEGRW_PARAM_CLEAR_EN
            ST_CLEAR: begin
                if (clr_idx == IW'(DEPTH - 1)) state_nx = ST_RUN;
            end
`endif
            default: state_nx = state_q;
        endcase
        take        = rd_fire || wr_fire || wr_eos || eos_fire;
        bus.addr_b  = !take;
        bus.write_b = !take;
        bus.dataW_b = !(wr_fire || wr_eos);
    end

    // Single memory write port: clear sweep or in-range write op
    always_comb begin
        mem_we = wr_fire && in_range;
        mem_wa = ridx;
        mem_wd = bus.dataW_d;
`ifdef SEGRW_PARAM_CLEAR_EN
        if (reset && state_q == ST_CLEAR) begin
            mem_we = 1'b1;
            mem_wa = clr_idx;
            mem_wd = '0;
        end
`endif
    end

    // State register
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
`ifdef SEGRW_PARAM_CLEAR_EN
            state_q <= ST_CLEAR;
`else
            state_q <= ST_RUN;
`endif
        end else begin
            state_q <= state_nx;
        end
    end

`ifdef SEGRW_PARAM_CLEAR_EN
    // Clear sweep index, restarts from 0 on every reset
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) clr_idx <= '0;
        else if (state_q == ST_CLEAR) clr_idx <= clr_idx + 1'b1;
    end
`endif

    // Memory array, contents survive reset
    always_ff @(posedge clock) begin
        if (mem_we) mem[mem_wa] <= mem_wd;
    end

    // Output slot: read data or eos marker, held while downstream stalls
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            vld_p1  <= 1'b0;
            rd_e_p1 <= 1'b0;
            rd_d_p1 <= '0;
        end else if (rd_fire) begin
            vld_p1  <= 1'b1;
            rd_e_p1 <= 1'b0;
            rd_d_p1 <= in_range ? mem[ridx] : '0;
        end else if (eos_fire || wr_eos) begin
            vld_p1  <= 1'b1;
            rd_e_p1 <= 1'b1;
            rd_d_p1 <= '0;
        end else if (!bus.dataR_b) begin
            vld_p1  <= 1'b0;
            rd_e_p1 <= 1'b0;
        end
    end

    // Sticky out-of-range flag for any fired read/write op
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) oob_q <= 1'b0;
        else if ((rd_fire || wr_fire || wr_eos) && !in_range) oob_q <= 1'b1;
    end

    assign bus.dataR_d = rd_d_p1;
    assign bus.dataR_e = rd_e_p1;
    assign bus.dataR_v = vld_p1;
    assign bus.oob     = oob_q;
endmodule

// File: tb/tb_segrw_param.sv
// Scoreboard bench for segrw_param (AW=4, DW=8, DEPTH=12 so that addresses
// 12..15 are out of range). Accepted ops update a plain array model of the
// memory and push the expected output token; a monitor pops on every output
// transfer. Honours SEGRW_PARAM_CLEAR_EN when the design is built with it.
module tb_segrw_param;
    localparam int AW    = 4;
    localparam int DW    = 8;
    localparam int DEPTH = 12;

    typedef struct packed {
        logic          e;
        logic [DW-1:0] d;
    } exp_t;

    logic clock;
    logic reset;

    segrw_param_if #(.AW(AW), .DW(DW)) bus ();

    segrw_param #(.AW(AW), .DW(DW), .DEPTH(DEPTH)) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus)
    );

    int            checks = 0;
    int            errors = 0;
    exp_t          expq[$];
    logic [DW-1:0] mdl_mem [DEPTH];
    bit            oob_exp  = 0;
    bit            oob_pend = 0;
    bit            bp_rand  = 0;
    bit            bp_force = 0;

    logic [AW-1:0] cur_a;
    bit            cur_ae, cur_wr, cur_we, cur_dwv, cur_dwe;
    logic [DW-1:0] cur_wd;

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    task automatic idle();
        bus.addr_v  = 1'b0; bus.addr_e  = 1'b0; bus.addr_d  = '0;
        bus.write_v = 1'b0; bus.write_e = 1'b0; bus.write_d = 1'b0;
        bus.dataW_v = 1'b0; bus.dataW_e = 1'b0; bus.dataW_d = '0;
    endtask

    task automatic drive_op(input logic [AW-1:0] a, input bit ae, input bit wr, input bit we,
                            input logic [DW-1:0] wd, input bit dwv, input bit dwe);
        cur_a = a; cur_ae = ae; cur_wr = wr; cur_we = we; cur_wd = wd; cur_dwv = dwv; cur_dwe = dwe;
        bus.addr_d  = a;  bus.addr_e  = ae; bus.addr_v  = 1'b1;
        bus.write_d = wr; bus.write_e = we; bus.write_v = 1'b1;
        bus.dataW_d = wd; bus.dataW_e = dwe; bus.dataW_v = dwv;
    endtask

    // Reference behaviour of one consumed op
    task automatic accept_model();
        exp_t x;
        bit   inr;
        inr = int'(cur_a) < DEPTH;
        if (cur_ae || cur_we) begin
            x.e = 1'b1; x.d = '0;
            expq.push_back(x);
        end else if (!cur_wr) begin
            x.e = 1'b0;
            x.d = inr ? mdl_mem[cur_a] : '0;
            expq.push_back(x);
            if (!inr) oob_pend = 1;
        end else begin
            if (!inr) oob_pend = 1;
            if (cur_dwe) begin
                x.e = 1'b1; x.d = '0;
                expq.push_back(x);
            end else if (inr) begin
                mdl_mem[cur_a] = cur_wd;
            end
        end
    endtask

    task automatic wait_accept(output int waited);
        bit dw_take;
        dw_take = !(cur_ae || cur_we) && cur_wr && cur_dwv;
        waited = -1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clock);
            if (!bus.addr_b) begin
                check("acc_write_b", 32'(bus.write_b), 32'(0));
                check("acc_dataW_b", 32'(bus.dataW_b), dw_take ? 32'(0) : 32'(1));
                accept_model();
                waited = i;
                @(posedge clock); #1;
                oob_exp  = oob_exp | oob_pend;
                oob_pend = 0;
                idle();
                return;
            end
        end
        checks++;
        errors++;
        $display("FAIL accept_timeout: op at addr %0h not consumed in 200 cycles, required acceptance", cur_a);
        idle();
    endtask

    task automatic send_op(input logic [AW-1:0] a, input bit ae, input bit wr, input bit we,
                           input logic [DW-1:0] wd, input bit dwv, input bit dwe);
        int w;
        drive_op(a, ae, wr, we, wd, dwv, dwe);
        wait_accept(w);
    endtask

    task automatic drain();
        bp_rand  = 0;
        bp_force = 0;
        for (int i = 0; i < 300 && expq.size() != 0; i++) @(posedge clock);
        check("drain_empty", 32'(expq.size()), 32'(0));
        @(posedge clock); #1;
    endtask

    task automatic do_reset();
        @(posedge clock); #1;
        reset = 1'b0;
        idle();
        bp_rand  = 0;
        bp_force = 0;
        @(negedge clock);
        check("rst_dataR_v", 32'(bus.dataR_v), 32'(0));
        check("rst_dataR_e", 32'(bus.dataR_e), 32'(0));
        check("rst_dataR_d", 32'(bus.dataR_d), 32'(0));
        check("rst_oob", 32'(bus.oob), 32'(0));
        expq.delete();
        oob_exp  = 0;
        oob_pend = 0;
`ifdef SEGRW_PARAM_CLEAR_EN
        for (int i = 0; i < DEPTH; i++) mdl_mem[i] = '0;
`endif
        @(posedge clock); #1;
        reset = 1'b1;
    endtask

    task automatic check_all_b(input string name);
        check({name, "_addr_b"}, 32'(bus.addr_b), 32'(1));
        check({name, "_write_b"}, 32'(bus.write_b), 32'(1));
        check({name, "_dataW_b"}, 32'(bus.dataW_b), 32'(1));
    endtask

    // Downstream back-pressure generator
    initial begin
        bus.dataR_b = 1'b0;
        forever begin
            @(posedge clock); #2;
            bus.dataR_b = bp_rand ? ($urandom_range(0, 3) == 0) : bp_force;
        end
    end

    // Output monitor: pops the scoreboard on each transfer, checks hold and oob
    initial begin
        exp_t          x;
        bit            prev_hold = 0;
        logic [DW-1:0] prev_d = '0;
        logic          prev_e = 1'b0;
        forever begin
            @(negedge clock);
            if (!reset) begin
                prev_hold = 0;
            end else begin
                if (prev_hold) begin
                    check("hold_v", 32'(bus.dataR_v), 32'(1));
                    check("hold_d", 32'(bus.dataR_d), 32'(prev_d));
                    check("hold_e", 32'(bus.dataR_e), 32'(prev_e));
                end
                check("oob", 32'(bus.oob), 32'(oob_exp));
                if (bus.dataR_v && !bus.dataR_b) begin
                    if (expq.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_out: got d=%0h e=%0b, required no token", bus.dataR_d, bus.dataR_e);
                    end else begin
                        x = expq.pop_front();
                        check("out_d", 32'(bus.dataR_d), 32'(x.d));
                        check("out_e", 32'(bus.dataR_e), 32'(x.e));
                    end
                end
                prev_hold = bus.dataR_v && bus.dataR_b;
                prev_d    = bus.dataR_d;
                prev_e    = bus.dataR_e;
            end
        end
    end

    initial begin
        #600000;
        errors++;
        $display("FAIL watchdog: run did not complete, required completion");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1, "watchdog expired");
    end

    // Main stimulus
    initial begin
        logic [AW-1:0] ra;
        logic [DW-1:0] rd;
        bit            rw;
        int            w;
        reset = 1'b0;
        idle();
        do_reset();

`ifdef SEGRW_PARAM_CLEAR_EN
        // CLEAR lasts DEPTH cycles, also after a reset in the middle of it
        drive_op(AW'(0), 0, 0, 0, '0, 0, 0);
        repeat (7) begin
            @(negedge clock);
            check_all_b("clr_a");
        end
        do_reset();
        drive_op(AW'(0), 0, 0, 0, '0, 0, 0);
        repeat (DEPTH) begin
            @(negedge clock);
            check_all_b("clr_b");
            check("clr_dataR_v", 32'(bus.dataR_v), 32'(0));
        end
        wait_accept(w);
        check("clr_len", 32'(w), 32'(0));
        for (int i = 1; i < DEPTH; i++) send_op(AW'(i), 0, 0, 0, '0, 0, 0);
        drain();
`endif

        // Known contents everywhere
        for (int i = 0; i < DEPTH; i++) send_op(AW'(i), 0, 1, 0, DW'($urandom_range(0, 255)), 1, 0);
        drain();

        // Write then read, one-cycle latency
        send_op(AW'(3), 0, 1, 0, 8'hA5, 1, 0);
        send_op(AW'(3), 0, 0, 0, '0, 0, 0);
        check("lat_v", 32'(bus.dataR_v), 32'(1));
        check("lat_d", 32'(bus.dataR_d), 32'(8'hA5));
        check("lat_oob", 32'(bus.oob), 32'(0));
        drain();

        // Out of range read/write, then verify no location moved
        send_op(AW'(13), 0, 0, 0, '0, 0, 0);
        check("oob_rd_d", 32'(bus.dataR_d), 32'(0));
        check("oob_set", 32'(bus.oob), 32'(1));
        send_op(AW'(13), 0, 1, 0, 8'h77, 1, 0);
        for (int i = 0; i < DEPTH; i++) send_op(AW'(i), 0, 0, 0, '0, 0, 0);
        drain();
        check("oob_sticky", 32'(bus.oob), 32'(1));

        // Stalled output slot holds and blocks the next read
        bp_force = 1;
        send_op(AW'(0), 0, 0, 0, '0, 0, 0);
        drive_op(AW'(1), 0, 0, 0, '0, 0, 0);
        repeat (3) begin
            @(negedge clock);
            check("bp_addr_b", 32'(bus.addr_b), 32'(1));
            check("bp_v", 32'(bus.dataR_v), 32'(1));
            check("bp_d", 32'(bus.dataR_d), 32'(mdl_mem[0]));
        end
        bp_force = 0;
        wait_accept(w);
        check("bp_rel_d1", 32'(bus.dataR_d), 32'(mdl_mem[1]));
        send_op(AW'(2), 0, 0, 0, '0, 0, 0);
        check("bp_rel_d2", 32'(bus.dataR_d), 32'(mdl_mem[2]));
        drain();

        // Random reads/writes with random back-pressure
        bp_rand = 1;
        for (int n = 0; n < 300; n++) begin
            ra = AW'($urandom_range(0, 15));
            rw = bit'($urandom_range(0, 1));
            rd = DW'($urandom_range(0, 255));
            send_op(ra, 0, rw, 0, rd, rw, 0);
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clock); #1;
            end
        end
        drain();

        // Address end-of-stream with a write token alongside
        send_op(AW'(2), 1, 1, 0, 8'h5A, 1, 0);
        check("eos_v", 32'(bus.dataR_v), 32'(1));
        check("eos_e", 32'(bus.dataR_e), 32'(1));
        drain();
        drive_op(AW'(4), 0, 1, 0, 8'h33, 1, 0);
        repeat (5) begin
            @(negedge clock);
            check_all_b("done1");
        end
        idle();
        check("done1_v", 32'(bus.dataR_v), 32'(0));

        // Write with dataW end-of-stream leaves memory untouched
        do_reset();
        send_op(AW'(5), 0, 1, 0, 8'h11, 1, 0);
        send_op(AW'(5), 0, 1, 0, 8'h99, 1, 1);
        drain();
        drive_op(AW'(6), 0, 0, 0, '0, 0, 0);
        repeat (4) begin
            @(negedge clock);
            check_all_b("done2");
        end
        idle();
        do_reset();
        send_op(AW'(5), 0, 0, 0, '0, 0, 0);
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
